// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates active-low columns, synchronizes rows,
// debounces press and release, and reports each accepted key once.
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:1] ROW,
    output logic [4:1] COL,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    logic [4:1]    r_sync1;
    logic [4:1]    r_sync2;
    logic [DW-1:0] r_div;
    state_t        r_state;
    logic [1:0]    r_col_idx;
    logic [1:0]    r_cand_row;
    logic [CW-1:0] r_match_cnt;
    logic [CW-1:0] r_rel_cnt;

    logic          w_edge;
    logic          w_pressed;
    logic [1:0]    w_row_idx;
    logic [1:0]    w_col_next;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'h0;
            4'hD:    code = 4'hF;
            4'hE:    code = 4'hE;
            4'hF:    code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [4:1] col_drive(input logic [1:0] idx);
        logic [4:1] drv;
        case (idx)
            2'd0:    drv = 4'b1110;
            2'd1:    drv = 4'b1101;
            2'd2:    drv = 4'b1011;
            2'd3:    drv = 4'b0111;
            default: drv = 4'b1110;
        endcase
        return drv;
    endfunction

    assign w_edge     = (r_div == DIV_LAST);
    assign w_col_next = r_col_idx + 2'd1;

    // A sample counts as a press only with exactly one row low; anything else reads as released
    always_comb begin
        w_pressed = 1'b0;
        w_row_idx = 2'd0;
        case (~r_sync2)
            4'b0001: begin w_pressed = 1'b1; w_row_idx = 2'd0; end
            4'b0010: begin w_pressed = 1'b1; w_row_idx = 2'd1; end
            4'b0100: begin w_pressed = 1'b1; w_row_idx = 2'd2; end
            4'b1000: begin w_pressed = 1'b1; w_row_idx = 2'd3; end
            default: begin w_pressed = 1'b0; w_row_idx = 2'd0; end
        endcase
    end

    // Row synchronizer and free-running scan divider
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_div   <= {DW{1'b0}};
        end else begin
            r_sync1 <= ROW;
            r_sync2 <= r_sync1;
            r_div   <= w_edge ? {DW{1'b0}} : r_div + DW'(1);
        end
    end

    // Scan / confirm / held sequencer; column and key outputs are all registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SCAN;
            r_col_idx   <= 2'd0;
            COL         <= 4'b1110;
            r_cand_row  <= 2'd0;
            r_match_cnt <= CNT_ZERO;
            r_rel_cnt   <= CNT_ZERO;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (w_edge) begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_pressed) begin
                            r_cand_row  <= w_row_idx;
                            r_match_cnt <= CNT_ONE;
                            r_state     <= ST_CONFIRM;
                        end else begin
                            r_col_idx <= w_col_next;
                            COL       <= col_drive(w_col_next);
                        end
                    end
                    ST_CONFIRM: begin
                        if (w_pressed && (w_row_idx == r_cand_row)) begin
                            if ((r_match_cnt + CNT_ONE) == CNT_DONE) begin
                                key_code    <= key_lookup(r_cand_row, r_col_idx);
                                key_valid   <= 1'b1;
                                key_held    <= 1'b1;
                                r_match_cnt <= CNT_ZERO;
                                r_rel_cnt   <= CNT_ZERO;
                                r_state     <= ST_HELD;
                            end else begin
                                r_match_cnt <= r_match_cnt + CNT_ONE;
                            end
                        end else begin
                            r_match_cnt <= CNT_ZERO;
                            r_state     <= ST_SCAN;
                            r_col_idx   <= w_col_next;
                            COL         <= col_drive(w_col_next);
                        end
                    end
                    ST_HELD: begin
                        // Any renewed press restarts the release debounce
                        if (w_pressed) begin
                            r_rel_cnt <= CNT_ZERO;
                        end else if ((r_rel_cnt + CNT_ONE) == CNT_DONE) begin
                            r_rel_cnt <= CNT_ZERO;
                            key_held  <= 1'b0;
                            r_state   <= ST_SCAN;
                            r_col_idx <= w_col_next;
                            COL       <= col_drive(w_col_next);
                        end else begin
                            r_rel_cnt <= r_rel_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_SCAN;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed scenarios and random
// press sequences checked every cycle against a behavioural reference.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 3;
    // key codes packed by index row*4+col, lowest nibble is R1/C1
    localparam logic [63:0] KMAP = {4'hD, 4'hE, 4'hF, 4'h0,
                                    4'hC, 4'h9, 4'h8, 4'h7,
                                    4'hB, 4'h6, 4'h5, 4'h4,
                                    4'hA, 4'h3, 4'h2, 4'h1};

    logic       clk;
    logic       reset;
    logic [4:1] row_pin;
    logic [4:1] col_pin;
    logic [3:0] code;
    logic       valid;
    logic       held;
    logic [15:0] keys;

    int n_checks;
    int n_errors;
    int j;
    int pulses;
    int pulse_j;
    int fall_j;
    logic [3:0] fall_col;
    logic prev_held;

    // reference model state
    int m_div;
    int m_mode;
    int m_col;
    int m_row;
    int m_cnt;
    int m_rel;
    logic [3:0] m_q1;
    logic [3:0] m_q2;
    logic [3:0] m_code;
    logic m_valid;
    logic m_held;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .ROW      (row_pin),
        .COL      (col_pin),
        .key_code (code),
        .key_valid(valid),
        .key_held (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] kp_rows(input logic [3:0] col, input logic [15:0] k);
        logic [3:0] rr;
        rr = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (k[r*4+c] && !col[c]) rr[r] = 1'b0;
        return rr;
    endfunction

    assign row_pin = kp_rows(col_pin, keys);

    function automatic logic [3:0] col_bits(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[c] = 1'b0;
        return v;
    endfunction

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] b;
        b = 16'h0;
        b[r*4+c] = 1'b1;
        return b;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at j=%0d: got %0h expected %0h", tag, j, got, exp);
        end
    endtask

    // Advance the model one clock from the rules, then clock the DUT and compare
    task automatic step();
        logic [3:0] rin;
        logic [3:0] rs;
        int nlow;
        int r;
        rin = kp_rows(col_bits(m_col), keys);
        if (reset) begin
            m_div = 0; m_mode = 0; m_col = 0; m_row = 0; m_cnt = 0; m_rel = 0;
            m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
            m_q1 = 4'hF; m_q2 = 4'hF;
        end else begin
            rs = m_q2;
            nlow = $countones(~rs);
            r = 0;
            for (int i = 3; i >= 0; i--) if (!rs[i]) r = i;
            m_valid = 1'b0;
            if (m_div == SD - 1) begin
                if (m_mode == 0) begin
                    if (nlow == 1) begin m_row = r; m_cnt = 1; m_mode = 1; end
                    else m_col = (m_col + 1) % 4;
                end else if (m_mode == 1) begin
                    if (nlow == 1 && r == m_row) begin
                        m_cnt++;
                        if (m_cnt == DB) begin
                            m_code = KMAP[(m_row*4+m_col)*4 +: 4];
                            m_valid = 1'b1; m_held = 1'b1; m_rel = 0; m_mode = 2;
                        end
                    end else begin
                        m_mode = 0; m_cnt = 0; m_col = (m_col + 1) % 4;
                    end
                end else begin
                    if (nlow == 1) m_rel = 0;
                    else m_rel++;
                    if (m_rel == DB) begin
                        m_mode = 0; m_rel = 0; m_held = 1'b0; m_col = (m_col + 1) % 4;
                    end
                end
            end
            m_div = (m_div + 1) % SD;
            m_q2 = m_q1;
            m_q1 = rin;
        end
        @(posedge clk);
        #1;
        j++;
        check_eq("col",   {28'd0, col_pin}, {28'd0, col_bits(m_col)});
        check_eq("valid", {31'd0, valid},   {31'd0, m_valid});
        check_eq("held",  {31'd0, held},    {31'd0, m_held});
        check_eq("code",  {28'd0, code},    {28'd0, m_code});
        if (valid) begin pulses++; pulse_j = j; end
        if (prev_held && !held) begin fall_j = j; fall_col = col_pin; end
        prev_held = held;
    endtask

    task automatic run_to(input int t);
        while (j < t) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        j = 0; pulses = 0; pulse_j = -1; fall_j = -1; fall_col = 4'h0;
    endtask

    initial begin
        int n;
        int sel;
        n_checks = 0; n_errors = 0; j = 0; prev_held = 1'b0;
        keys = 16'h0; reset = 1'b1;

        // 1: idle rotation
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_to(4*k);
            check_eq("idle_col", {28'd0, col_pin}, {28'd0, col_bits(k % 4)});
        end
        check_eq("idle_pulses", pulses, 0);

        // 2: hold "5", then release
        do_reset();
        keys = key_bit(1, 1);
        run_to(40);
        check_eq("k5_pulses", pulses, 1);
        check_eq("k5_latency", pulse_j, 16);
        check_eq("k5_code", {28'd0, code}, 32'h5);
        check_eq("k5_col", {28'd0, col_pin}, 32'hD);
        keys = 16'h0;
        run_to(60);
        check_eq("k5_fall_j", fall_j, 52);
        check_eq("k5_fall_col", {28'd0, fall_col}, 32'hB);

        // 3: "D" released mid-confirm
        do_reset();
        keys = key_bit(3, 3);
        run_to(19);
        keys = 16'h0;
        run_to(24);
        check_eq("kd_col", {28'd0, col_pin}, 32'hE);
        run_to(40);
        check_eq("kd_pulses", pulses, 0);

        // 4: "1"+"4" invalid, then "1" alone
        do_reset();
        keys = key_bit(0, 0) | key_bit(1, 0);
        run_to(20);
        check_eq("k14_pulses", pulses, 0);
        keys = key_bit(0, 0);
        run_to(50);
        check_eq("k1_pulses", pulses, 1);
        check_eq("k1_latency", pulse_j, 44);
        check_eq("k1_code", {28'd0, code}, 32'h1);

        // 5: "A" with a short release bounce
        do_reset();
        keys = key_bit(0, 3);
        run_to(25);
        check_eq("ka_pulse_j", pulse_j, 24);
        keys = 16'h0;
        run_to(32);
        keys = key_bit(0, 3);
        run_to(60);
        check_eq("ka_pulses", pulses, 1);
        check_eq("ka_held", {31'd0, held}, 32'h1);
        check_eq("ka_code", {28'd0, code}, 32'hA);

        // 6: reset while "0" is held
        do_reset();
        keys = key_bit(3, 0);
        run_to(20);
        check_eq("k0_held", {31'd0, held}, 32'h1);
        do_reset();
        check_eq("rst_col", {28'd0, col_pin}, 32'hE);
        check_eq("rst_code", {28'd0, code}, 32'h0);
        check_eq("rst_held", {31'd0, held}, 32'h0);
        check_eq("rst_valid", {31'd0, valid}, 32'h0);
        run_to(20);
        check_eq("k0_pulses", pulses, 1);
        check_eq("k0_latency", pulse_j, 12);
        check_eq("k0_code", {28'd0, code}, 32'h0);

        // random key activity against the model
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            sel = $urandom_range(0, 9);
            if (sel < 3) keys = 16'h0;
            else if (sel < 8) keys = key_bit($urandom_range(0, 3), $urandom_range(0, 3));
            else keys = key_bit($urandom_range(0, 3), $urandom_range(0, 3))
                      | key_bit($urandom_range(0, 3), $urandom_range(0, 3));
            n = $urandom_range(4, 60);
            run_to(j + n);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
